// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and width helpers for the parametrised FIFO.
//   ptr_w(depth) : pointer width, never less than 1 bit
//   cnt_w(depth) : occupancy counter width, able to hold 0..depth
//   fifo_acc_t   : per-cycle accept decode {wr_acc, rd_acc}
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_DEPTH) + 1;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic wr_acc;
    logic rd_acc;
  } fifo_acc_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-around pointer register.
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset, pointer -> 0
//   clear : synchronous return to 0, wins over inc
//   inc   : advance by one; wraps naturally at 2**W
//   ptr   : current pointer value
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_reg;
  logic [W-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (clear) begin
      ptr_next = '0;
    end else if (inc) begin
      ptr_next = ptr_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_param.sv
// fifo_param: single-clock FIFO, parametrised width/depth, with occupancy
// count, programmable almost-full/almost-empty, sticky error flags and a
// synchronous clear.
//   clk, n_rst              : clock and asynchronous active-low reset
//   clear                   : flush contents and error flags (beats push/pop)
//   write_enable, wdata     : push request and data
//   read_enable, rdata      : pop request; rdata registered, valid next cycle
//   full, empty             : count == DEPTH / count == 0
//   almost_full/almost_empty: count >= AF_LEVEL / count <= AE_LEVEL
//   count                   : occupancy 0..DEPTH
//   overflow, underflow     : sticky rejected-write / rejected-read flags
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   write_enable,
  input  logic                   read_enable,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic [DATA_W-1:0] rdata_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  fifo_acc_t         acc;

  // Status is decoded from the registered count only, so it never glitches
  // within a clock period.
  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign almost_full  = (int'(count_reg) >= AF_LEVEL);
  assign almost_empty = (int'(count_reg) <= AE_LEVEL);

  // A write into a full FIFO is still accepted when a read frees a slot in
  // the same cycle. There is no empty bypass: a read of an empty FIFO is
  // rejected even if a write arrives alongside it. Clear discards both.
  always_comb begin
    acc.wr_acc = !clear && write_enable && (!full || read_enable);
    acc.rd_acc = !clear && read_enable && !empty;
  end

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else begin
      count_next = count_reg + {{(CW-1){1'b0}}, acc.wr_acc}
                             - {{(CW-1){1'b0}}, acc.rd_acc};
    end
  end

  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .inc   (acc.wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .inc   (acc.rd_acc),
    .ptr   (rd_ptr)
  );

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (acc.wr_acc) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg     <= '0;
      rdata_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clear) begin
      count_reg     <= '0;
      rdata_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (acc.rd_acc) begin
        rdata_reg <= mem[rd_ptr];
      end
      if (write_enable && full && !read_enable) begin
        overflow_reg <= 1'b1;
      end
      if (read_enable && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign count     = count_reg;
  assign rdata     = rdata_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          clear;
  logic          write_enable;
  logic          read_enable;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          full, empty, almost_full, almost_empty;
  logic [2:0]    count;
  logic          overflow, underflow;

  int checks = 0;
  int errors = 0;

  fifo_param #(.DATA_W(DW), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .wdata        (wdata),
    .rdata        (rdata),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // {count, full, empty, almost_full, almost_empty, overflow, underflow}
  wire [8:0] st = {count, full, empty, almost_full, almost_empty, overflow, underflow};

  // Expected status for DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
  function automatic logic [8:0] exp_st(input int c, input bit ov, input bit uf);
    return {3'(c), c == 4, c == 0, c >= 3, c <= 1, ov, uf};
  endfunction

  // One clock of stimulus; outputs are stable #1 after the edge on return.
  task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d);
    write_enable = w;
    read_enable  = r;
    wdata        = d;
    @(posedge clk);
    #1;
    $display("txn t=%0t we=%0b re=%0b wdata=%h rdata=%h count=%0d ov=%0b uf=%0b",
             $time, w, r, d, rdata, count, overflow, underflow);
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    $display("txn t=%0t clear count=%0d", $time, count);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; clear = 1'b0; write_enable = 1'b0; read_enable = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    checks++;
    if (st !== exp_st(0, 0, 0)) begin
      errors++; $display("FAIL reset_status got %b exp %b", st, exp_st(0, 0, 0));
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h exp %h", rdata, 32'h0);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 32'hA0 + i);
      checks++;
      if (st !== exp_st(i + 1, 0, 0)) begin
        errors++; $display("FAIL fill_status[%0d] got %b exp %b", i, st, exp_st(i + 1, 0, 0));
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, '0);
      checks++;
      if (rdata !== 32'hA0 + i || st !== exp_st(3 - i, 0, 0)) begin
        errors++; $display("FAIL drain[%0d] got rdata=%h st=%b exp rdata=%h st=%b",
                           i, rdata, st, 32'hA0 + i, exp_st(3 - i, 0, 0));
      end
    end
    cycle(0, 1, '0);
    checks++;
    if (rdata !== 32'hA3 || st !== exp_st(0, 0, 1)) begin
      errors++; $display("FAIL underflow got rdata=%h st=%b exp rdata=%h st=%b",
                         rdata, st, 32'hA3, exp_st(0, 0, 1));
    end
  endtask

  task automatic test_wrap();
    do_clear();
    checks++;
    if (st !== exp_st(0, 0, 0) || rdata !== 32'h0) begin
      errors++; $display("FAIL clear_flags got st=%b rdata=%h exp st=%b rdata=0",
                         st, rdata, exp_st(0, 0, 0));
    end
    cycle(1, 0, 32'h10);
    for (int i = 1; i < 6; i++) begin
      cycle(1, 1, 32'h10 + i);
      checks++;
      if (rdata !== 32'h10 + i - 1 || st !== exp_st(1, 0, 0)) begin
        errors++; $display("FAIL wrap[%0d] got rdata=%h st=%b exp rdata=%h st=%b",
                           i, rdata, st, 32'h10 + i - 1, exp_st(1, 0, 0));
      end
    end
    cycle(0, 1, '0);
    checks++;
    if (rdata !== 32'h15 || st !== exp_st(0, 0, 0)) begin
      errors++; $display("FAIL wrap_last got rdata=%h st=%b exp rdata=%h st=%b",
                         rdata, st, 32'h15, exp_st(0, 0, 0));
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'hB0 + i);
    cycle(1, 0, 32'hDEAD);
    checks++;
    if (st !== exp_st(4, 1, 0)) begin
      errors++; $display("FAIL overflow_set got %b exp %b", st, exp_st(4, 1, 0));
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, '0);
      checks++;
      if (rdata !== 32'hB0 + i || st !== exp_st(3 - i, 1, 0)) begin
        errors++; $display("FAIL ovf_read[%0d] got rdata=%h st=%b exp rdata=%h st=%b",
                           i, rdata, st, 32'hB0 + i, exp_st(3 - i, 1, 0));
      end
    end
    do_clear();
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'hC0 + i);
    cycle(1, 1, 32'hBEEF);
    checks++;
    if (rdata !== 32'hC0 || st !== exp_st(4, 0, 0)) begin
      errors++; $display("FAIL full_both got rdata=%h st=%b exp rdata=%h st=%b",
                         rdata, st, 32'hC0, exp_st(4, 0, 0));
    end
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] e;
      e = (i == 3) ? 32'hBEEF : 32'hC1 + i;
      cycle(0, 1, '0);
      checks++;
      if (rdata !== e || st !== exp_st(3 - i, 0, 0)) begin
        errors++; $display("FAIL beef_read[%0d] got rdata=%h st=%b exp rdata=%h st=%b",
                           i, rdata, st, e, exp_st(3 - i, 0, 0));
      end
    end
  endtask

  task automatic test_empty_both();
    cycle(1, 1, 32'h55);
    checks++;
    if (rdata !== 32'hBEEF || st !== exp_st(1, 0, 1)) begin
      errors++; $display("FAIL empty_both got rdata=%h st=%b exp rdata=%h st=%b",
                         rdata, st, 32'hBEEF, exp_st(1, 0, 1));
    end
    cycle(0, 1, '0);
    checks++;
    if (rdata !== 32'h55 || st !== exp_st(0, 0, 1)) begin
      errors++; $display("FAIL empty_both_read got rdata=%h st=%b exp rdata=%h st=%b",
                         rdata, st, 32'h55, exp_st(0, 0, 1));
    end
  endtask

  task automatic test_clear_reset();
    do_clear();
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'hD0 + i);
    cycle(1, 0, 32'hDEAD);
    cycle(0, 1, '0);
    checks++;
    if (rdata !== 32'hD0 || st !== exp_st(3, 1, 0)) begin
      errors++; $display("FAIL pre_clear got rdata=%h st=%b exp rdata=%h st=%b",
                         rdata, st, 32'hD0, exp_st(3, 1, 0));
    end
    clear = 1'b1;
    cycle(1, 0, 32'h77);
    clear = 1'b0;
    checks++;
    if (rdata !== 32'h0 || st !== exp_st(0, 0, 0)) begin
      errors++; $display("FAIL clear_with_write got rdata=%h st=%b exp rdata=0 st=%b",
                         rdata, st, exp_st(0, 0, 0));
    end
    cycle(1, 0, 32'hE0);
    cycle(1, 1, 32'hE1);
    checks++;
    if (rdata !== 32'hE0 || st !== exp_st(1, 0, 0)) begin
      errors++; $display("FAIL burst got rdata=%h st=%b exp rdata=%h st=%b",
                         rdata, st, 32'hE0, exp_st(1, 0, 0));
    end
    // Reset asserted mid-burst, between clock edges.
    write_enable = 1'b1;
    wdata        = 32'hE2;
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h0 || st !== exp_st(0, 0, 0)) begin
      errors++; $display("FAIL async_reset got rdata=%h st=%b exp rdata=0 st=%b",
                         rdata, st, exp_st(0, 0, 0));
    end
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    n_rst        = 1'b1;
    cycle(1, 0, 32'hF0);
    checks++;
    if (st !== exp_st(1, 0, 0) || dut.mem[0] !== 32'hF0) begin
      errors++; $display("FAIL post_reset_write got st=%b mem0=%h exp st=%b mem0=%h",
                         st, dut.mem[0], exp_st(1, 0, 0), 32'hF0);
    end
    cycle(0, 1, '0);
    checks++;
    if (rdata !== 32'hF0 || st !== exp_st(0, 0, 0)) begin
      errors++; $display("FAIL post_reset_read got rdata=%h st=%b exp rdata=%h st=%b",
                         rdata, st, 32'hF0, exp_st(0, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_overflow();
    test_empty_both();
    test_clear_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
